countdown_timer: RTL and testbench

- MM:SS BCD countdown timer. Sits directly downstream of the mod-N down-counter/prescaler stage and consumes its single-cycle carry as a 1 Hz `tick` enable.
- Holds four BCD digits: minute tens, minute ones, second tens, second ones.
- Supports load, start, pause/resume and clear, and flags expiry for the calendar alarm logic.

---
 rtl/countdown_timer.sv | 75 +++++++
 tb/tb_countdown_timer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS BCD countdown with load/start/pause/clear and expiry flags
module countdown_timer #(
  parameter logic [3:0] MT_MAX = 4'd9,
  parameter logic [3:0] ST_MAX = 4'd5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_bcd,
  input  logic        start,
  input  logic        pause,
  output logic [15:0] digits,
  output logic        running,
  output logic        done,
  output logic        expired
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] digits_q, digits_d, dec, sat;
  logic [3:0] mt, mo, st, so;
  logic b0, b1, b2, done_d, done_q, running_q, expired_q;
  assign {mt, mo, st, so} = digits_q;
  assign b0 = so == 4'd0;
  assign b1 = b0 && st == 4'd0;
  assign b2 = b1 && mo == 4'd0;
  assign dec = {b2 ? mt - 4'd1 : mt,
                b1 ? (mo == 4'd0 ? 4'd9 : mo - 4'd1) : mo,
                b0 ? (st == 4'd0 ? ST_MAX : st - 4'd1) : st,
                b0 ? 4'd9 : so - 4'd1};
  assign sat = {load_bcd[15:12] > MT_MAX ? MT_MAX : load_bcd[15:12],
                load_bcd[11:8] > 4'd9 ? 4'd9 : load_bcd[11:8],
                load_bcd[7:4] > ST_MAX ? ST_MAX : load_bcd[7:4],
                load_bcd[3:0] > 4'd9 ? 4'd9 : load_bcd[3:0]};
  always_comb begin
    state_d = state_q;
    digits_d = digits_q;
    done_d = 1'b0;
    if (clear) begin
      state_d = IDLE;
      digits_d = 16'h0000;
    end else if (load && state_q != RUN) begin
      state_d = IDLE;
      digits_d = sat;
    end else if (start && state_q == IDLE && digits_q != 16'h0000) begin
      state_d = RUN;
    end else if (pause && (state_q == RUN || state_q == PAUSE)) begin
      state_d = state_q == RUN ? PAUSE : RUN;
    end else if (tick && state_q == RUN) begin
      digits_d = dec;
      state_d = dec == 16'h0000 ? DONE : RUN;
      done_d = dec == 16'h0000;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      digits_q <= 16'h0000;
      done_q <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q <= state_d;
      digits_q <= digits_d;
      done_q <= done_d;
      running_q <= state_d == RUN;
      expired_q <= state_d == DONE;
    end
  end
  assign digits = digits_q;
  assign running = running_q;
  assign done = done_q;
  assign expired = expired_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed bench with a seconds-based reference model
module tb_countdown_timer;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, clear = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [15:0] load_bcd = 16'h0000;
  logic [15:0] digits;
  logic running, done, expired;
  int n_checks = 0, n_pass = 0;
  bit finished = 1'b0;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;
  int m_sec = 0, m_st = S_IDLE;
  bit m_done = 1'b0;

  countdown_timer dut (
    .clk(clk), .rst(rst), .tick(tick), .clear(clear), .load(load), .load_bcd(load_bcd),
    .start(start), .pause(pause), .digits(digits), .running(running), .done(done), .expired(expired)
  );

  always #5 clk = ~clk;

  function automatic int sat_sec(input logic [15:0] v);
    int a, b, c, d;
    a = v[15:12] > 9 ? 9 : int'(v[15:12]);
    b = v[11:8] > 9 ? 9 : int'(v[11:8]);
    c = v[7:4] > 5 ? 5 : int'(v[7:4]);
    d = v[3:0] > 9 ? 9 : int'(v[3:0]);
    return a * 600 + b * 60 + c * 10 + d;
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  always @(posedge clk or posedge rst) begin
    m_done = 1'b0;
    if (rst) begin
      m_sec = 0;
      m_st = S_IDLE;
    end else if (clear) begin
      m_sec = 0;
      m_st = S_IDLE;
    end else if (load && m_st != S_RUN) begin
      m_sec = sat_sec(load_bcd);
      m_st = S_IDLE;
    end else if (start && m_st == S_IDLE && m_sec != 0) begin
      m_st = S_RUN;
    end else if (pause && (m_st == S_RUN || m_st == S_PAUSE)) begin
      m_st = m_st == S_RUN ? S_PAUSE : S_RUN;
    end else if (tick && m_st == S_RUN) begin
      m_sec = m_sec - 1;
      if (m_sec == 0) begin
        m_st = S_DONE;
        m_done = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!finished) begin
      check("model_digits", digits, to_bcd(m_sec));
      check("model_running", 16'(running), 16'(m_st == S_RUN));
      check("model_done", 16'(done), 16'(m_done));
      check("model_expired", 16'(expired), 16'(m_st == S_DONE));
    end
  end

  task automatic cyc(input logic c, input logic l, input logic s, input logic p, input logic t,
                     input logic [15:0] v);
    clear = c; load = l; start = s; pause = p; tick = t; load_bcd = v;
    @(posedge clk);
    #1;
    clear = 0; load = 0; start = 0; pause = 0; tick = 0; load_bcd = 16'h0000;
    @(negedge clk);
    #1;
  endtask

  task automatic ld(input logic [15:0] v); cyc(0, 1, 0, 0, 0, v); endtask
  task automatic go(); cyc(0, 0, 1, 0, 0, 16'h0); endtask
  task automatic ticks(input int n); for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1, 16'h0); endtask
  task automatic clr(); cyc(1, 0, 0, 0, 0, 16'h0); endtask

  initial begin
    #2;
    check("reset_digits", digits, 16'h0000);
    check("reset_running", 16'(running), 16'd0);
    check("reset_done", 16'(done), 16'd0);
    check("reset_expired", 16'(expired), 16'd0);
    @(negedge clk); @(negedge clk); #1;
    rst = 0;
    ld(16'h0012); go(); ticks(3);
    check("run_digits", digits, 16'h0009);
    check("run_running", 16'(running), 16'd1);
    rst = 1;
    #1;
    check("async_rst_digits", digits, 16'h0000);
    check("async_rst_running", 16'(running), 16'd0);
    check("async_rst_expired", 16'(expired), 16'd0);
    @(negedge clk); #1;
    rst = 0;
    ld(16'h1000); go(); ticks(1);
    check("borrow_1000", digits, 16'h0959);
    clr(); ld(16'h0100); go(); ticks(1);
    check("borrow_0100", digits, 16'h0059);
    clr(); ld(16'h0003); go(); ticks(2);
    check("pre_expiry_done", 16'(done), 16'd0);
    ticks(1);
    check("expiry_digits", digits, 16'h0000);
    check("expiry_done", 16'(done), 16'd1);
    check("expiry_expired", 16'(expired), 16'd1);
    check("expiry_running", 16'(running), 16'd0);
    ticks(5);
    check("post_expiry_done", 16'(done), 16'd0);
    check("post_expiry_expired", 16'(expired), 16'd1);
    check("post_expiry_digits", digits, 16'h0000);
    go();
    check("start_in_done", 16'(running), 16'd0);
    check("start_in_done_expired", 16'(expired), 16'd1);
    ld(16'h0030);
    check("load_clears_expired", 16'(expired), 16'd0);
    go(); ticks(2);
    check("pause_pre", digits, 16'h0028);
    cyc(0, 0, 0, 1, 1, 16'h0);
    check("pause_tick_digits", digits, 16'h0028);
    check("pause_tick_running", 16'(running), 16'd0);
    ticks(4);
    check("paused_hold", digits, 16'h0028);
    cyc(0, 0, 0, 1, 0, 16'h0);
    check("resume_running", 16'(running), 16'd1);
    ticks(1);
    check("resume_tick", digits, 16'h0027);
    ld(16'h1234);
    check("load_in_run_digits", digits, 16'h0027);
    check("load_in_run_running", 16'(running), 16'd1);
    clr(); ld(16'hFA7C);
    check("saturate", digits, 16'h9959);
    ticks(2);
    check("idle_tick_hold", digits, 16'h9959);
    clr(); go();
    check("start_zero_running", 16'(running), 16'd0);
    check("start_zero_done", 16'(done), 16'd0);
    ld(16'h0042);
    cyc(1, 1, 1, 0, 0, 16'h0042);
    check("prio_clear_digits", digits, 16'h0000);
    check("prio_clear_running", 16'(running), 16'd0);
    cyc(0, 1, 1, 0, 0, 16'h0005);
    check("prio_load_digits", digits, 16'h0005);
    check("prio_load_running", 16'(running), 16'd0);
    go();
    check("restart_running", 16'(running), 16'd1);
    ticks(5);
    check("final_done", 16'(done), 16'd1);
    check("final_digits", digits, 16'h0000);
    finished = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
